ita_activation_ctrl: RTL and testbench

Layer-level sequencer for the activation/requant pipeline (GELU/ReLU/Identity + requantizer).
- Accepts per-layer configuration through a double-buffered handshake and drives it onto the activation unit.
- Gates N-vector issue with a downstream credit counter and tracks in-flight vectors through a fixed-latency delay line, so out_valid_o/out_last_o align with the activation unit's data output.
- Holds configuration stable until the pipeline has fully drained, because the activation unit uses the mode both at input and at its delayed output stage.

---
 rtl/ita_activation_ctrl_pkg.sv | 41 ++++
 rtl/ita_activation_ctrl_delay.sv | 44 ++++
 rtl/ita_activation_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ita_activation_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_activation_ctrl_pkg.sv
// Shared types and constants for the activation/requant layer sequencer.
// Optional perf counters are built when ITA_ACT_CTRL_PERF_EN is defined.
package ita_activation_ctrl_pkg;

    localparam int unsigned ActLatency = 4;
    localparam int unsigned VecCntW = 16;

    typedef enum logic [1:0] {
        Identity = 2'd0,
        Relu     = 2'd1,
        Gelu     = 2'd2
    } activation_e;

    typedef enum logic {
        RqSigned   = 1'b0,
        RqUnsigned = 1'b1
    } requant_mode_e;

    typedef logic [7:0] requant_const_t;
    typedef logic [7:0] requant_t;
    typedef logic [15:0] gelu_const_t;

    typedef struct packed {
        activation_e          activation;
        requant_mode_e        requant_mode;
        requant_const_t       requant_mult;
        requant_const_t       requant_shift;
        requant_t             requant_add;
        gelu_const_t          gelu_one;
        gelu_const_t          gelu_b;
        gelu_const_t          gelu_c;
        logic [VecCntW-1:0]   num_vec;
    } act_ctrl_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } act_ctrl_state_e;

endpackage

// File: rtl/ita_activation_ctrl_delay.sv
// Fixed-latency {valid,last} tracker mirroring the activation pipeline.
// Never stalls: the activation unit itself cannot stall.
module ita_activation_ctrl_delay
    import ita_activation_ctrl_pkg::*;
#(
    parameter int unsigned LATENCY = ActLatency
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_valid_i,
    input  logic push_last_i,
    output logic valid_o,
    output logic last_o,
    output logic empty_o,
    output logic empty_next_o
);

    localparam logic [LATENCY-1:0] TopBit = LATENCY'(1) << (LATENCY - 1);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q[0] <= push_valid_i;
            last_q[0]  <= push_valid_i & push_last_i;
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign last_o  = last_q[LATENCY-1];
    assign empty_o = ~|valid_q;

    // Empty after this edge, provided nothing is pushed this cycle.
    assign empty_next_o = ~|(valid_q & ~TopBit);

endmodule

// File: rtl/ita_activation_ctrl.sv
// Layer sequencer for the activation/requant pipeline: config shadowing,
// credit-gated issue, drain tracking. Perf counters: ITA_ACT_CTRL_PERF_EN.
module ita_activation_ctrl
    import ita_activation_ctrl_pkg::*;
#(
    parameter int unsigned ACT_LATENCY = ActLatency,
    parameter int unsigned CREDITS     = 8,
    parameter int unsigned VEC_CNT_W   = VecCntW
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           cfg_valid_i,
    output logic           cfg_ready_o,
    input  act_ctrl_cfg_t  cfg_i,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic           credit_return_i,
    output activation_e    activation_o,
    output requant_mode_e  requant_mode_o,
    output requant_const_t requant_mult_o,
    output requant_const_t requant_shift_o,
    output requant_t       requant_add_o,
    output gelu_const_t    gelu_one_o,
    output gelu_const_t    gelu_b_o,
    output gelu_const_t    gelu_c_o,
    output logic           act_calc_en_o,
    output logic           out_valid_o,
    output logic           out_last_o,
    output logic           busy_o,
    output logic           layer_done_o,
    output logic           err_o,
    output logic [31:0]    perf_stall_o,
    output logic [31:0]    perf_busy_o
);

    localparam int unsigned CntW = $clog2(CREDITS + 1);
    localparam logic [CntW-1:0] CreditsMax = CntW'(CREDITS);
    localparam logic [CntW-1:0] CreditOne = CntW'(1);
    localparam logic [VEC_CNT_W-1:0] VecOne = VEC_CNT_W'(1);

    act_ctrl_state_e      state;
    act_ctrl_cfg_t        shadow;
    logic                 shadow_valid;
    logic [VEC_CNT_W-1:0] remaining;
    logic [CntW-1:0]      credits;

    logic accept;
    logic cfg_fire;
    logic load;
    logic dl_empty;
    logic dl_empty_next;

    assign cfg_ready_o = !shadow_valid;
    assign cfg_fire    = cfg_valid_i & cfg_ready_o;

    assign in_ready_o = (state == RUN) && (credits != '0)
                        && (remaining != '0);
    assign accept        = in_valid_i & in_ready_o;
    assign act_calc_en_o = accept;

    // The unit reads mode at input and at output, so only swap once drained.
    assign load = (state == IDLE) && shadow_valid && dl_empty;

    assign busy_o = (state != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            shadow          <= '0;
            shadow_valid    <= 1'b0;
            remaining       <= '0;
            layer_done_o    <= 1'b0;
            activation_o    <= Identity;
            requant_mode_o  <= RqSigned;
            requant_mult_o  <= '0;
            requant_shift_o <= '0;
            requant_add_o   <= '0;
            gelu_one_o      <= '0;
            gelu_b_o        <= '0;
            gelu_c_o        <= '0;
        end else begin
            layer_done_o <= 1'b0;
            if (cfg_fire) begin
                shadow       <= cfg_i;
                shadow_valid <= 1'b1;
            end else if (load) begin
                shadow_valid <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (load) begin
                        activation_o    <= shadow.activation;
                        requant_mode_o  <= shadow.requant_mode;
                        requant_mult_o  <= shadow.requant_mult;
                        requant_shift_o <= shadow.requant_shift;
                        requant_add_o   <= shadow.requant_add;
                        gelu_one_o      <= shadow.gelu_one;
                        gelu_b_o        <= shadow.gelu_b;
                        gelu_c_o        <= shadow.gelu_c;
                        remaining       <= VEC_CNT_W'(shadow.num_vec);
                        state <= (shadow.num_vec == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - VecOne;
                        if (remaining == VecOne) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (dl_empty_next) begin
                        layer_done_o <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            credits <= CreditsMax;
            err_o   <= 1'b0;
        end else begin
            unique case ({accept, credit_return_i})
                2'b10: credits <= credits - CreditOne;
                2'b01: begin
                    if (credits == CreditsMax) begin
                        err_o <= 1'b1;
                    end else begin
                        credits <= credits + CreditOne;
                    end
                end
                default: ;
            endcase
        end
    end

    ita_activation_ctrl_delay #(
        .LATENCY(ACT_LATENCY)
    ) u_delay (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_valid_i(accept),
        .push_last_i (remaining == VecOne),
        .valid_o     (out_valid_o),
        .last_o      (out_last_o),
        .empty_o     (dl_empty),
        .empty_next_o(dl_empty_next)
    );

`ifdef ITA_ACT_CTRL_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] busy_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
            busy_q  <= '0;
        end else begin
            if ((state == RUN) && in_valid_i && (remaining != '0)
                && (credits == '0)) begin
                stall_q <= stall_q + 32'd1;
            end
            if (busy_o) begin
                busy_q <= busy_q + 32'd1;
            end
        end
    end

    assign perf_stall_o = stall_q;
    assign perf_busy_o  = busy_q;
`else
    assign perf_stall_o = '0;
    assign perf_busy_o  = '0;
`endif

endmodule

// File: tb/tb_ita_activation_ctrl.sv
// Directed bench for ita_activation_ctrl; inputs driven and outputs
// sampled on the falling clock edge.
module tb_ita_activation_ctrl;
    import ita_activation_ctrl_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    act_ctrl_cfg_t  cfg = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic           credit_ret = 1'b0;
    activation_e    activation;
    requant_mode_e  requant_mode;
    requant_const_t requant_mult;
    requant_const_t requant_shift;
    requant_t       requant_add;
    gelu_const_t    gelu_one;
    gelu_const_t    gelu_b;
    gelu_const_t    gelu_c;
    logic           act_calc_en;
    logic           out_valid;
    logic           out_last;
    logic           busy;
    logic           layer_done;
    logic           err;
    logic [31:0]    perf_stall;
    logic [31:0]    perf_busy;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int cnt;
    logic found;
    logic [16:0] rdy_t, ov_t, last_t, done_t;

    always #5 clk = ~clk;

    ita_activation_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .cfg_i          (cfg),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .credit_return_i(credit_ret),
        .activation_o   (activation),
        .requant_mode_o (requant_mode),
        .requant_mult_o (requant_mult),
        .requant_shift_o(requant_shift),
        .requant_add_o  (requant_add),
        .gelu_one_o     (gelu_one),
        .gelu_b_o       (gelu_b),
        .gelu_c_o       (gelu_c),
        .act_calc_en_o  (act_calc_en),
        .out_valid_o    (out_valid),
        .out_last_o     (out_last),
        .busy_o         (busy),
        .layer_done_o   (layer_done),
        .err_o          (err),
        .perf_stall_o   (perf_stall),
        .perf_busy_o    (perf_busy)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic act_ctrl_cfg_t mk_cfg(activation_e a, int nv);
        act_ctrl_cfg_t c;
        c.activation    = a;
        c.requant_mode  = RqUnsigned;
        c.requant_mult  = 8'h5a;
        c.requant_shift = 8'd3;
        c.requant_add   = 8'hf0;
        c.gelu_one      = 16'h0100;
        c.gelu_b        = 16'h0a0b;
        c.gelu_c        = 16'h0c0d;
        c.num_vec       = 16'(nv);
        return c;
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        in_valid   = 1'b0;
        credit_ret = 1'b0;
        cfg        = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_done", 32'(layer_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_act", 32'(activation), 32'(Identity));
        chk("rst_mult", 32'(requant_mult), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_cfg_ready", 32'(cfg_ready), 1);
    endtask

    task automatic cyc_chk(string t, int i);
        chk($sformatf("%s_rdy%0d", t, i), 32'(in_ready), 32'(rdy_t[i]));
        chk($sformatf("%s_en%0d", t, i), 32'(act_calc_en), 32'(rdy_t[i]));
        chk($sformatf("%s_ov%0d", t, i), 32'(out_valid), 32'(ov_t[i]));
        chk($sformatf("%s_last%0d", t, i), 32'(out_last), 32'(last_t[i]));
        chk($sformatf("%s_done%0d", t, i), 32'(layer_done), 32'(done_t[i]));
    endtask

    initial begin
        #2;
        // T1: Relu, 3 vectors, latency 4
        do_reset();
        cfg = mk_cfg(Relu, 3);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("t1_cfg_ready_n1", 32'(cfg_ready), 0);
        chk("t1_busy_n1", 32'(busy), 0);
        in_valid = 1'b1;
        rdy_t  = 17'b0_0000_0000_0001_1100;
        ov_t   = 17'b0_0000_0001_1100_0000;
        last_t = 17'b0_0000_0001_0000_0000;
        done_t = 17'b0_0000_0010_0000_0000;
        for (int i = 2; i <= 10; i++) begin
            @(negedge clk);
            cyc_chk("t1", i);
            if (i == 2) begin
                chk("t1_act", 32'(activation), 32'(Relu));
                chk("t1_mode", 32'(requant_mode), 32'(RqUnsigned));
                chk("t1_mult", 32'(requant_mult), 32'h5a);
                chk("t1_gelu_c", 32'(gelu_c), 32'h0c0d);
            end
        end
        in_valid = 1'b0;

        // T3: Gelu queued behind a running Relu layer
        do_reset();
        cfg = mk_cfg(Relu, 3);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid = 1'b1;
        rdy_t  = 17'b0_0000_1100_0001_1100;
        ov_t   = 17'b0_1100_0001_1100_0000;
        last_t = 17'b0_1000_0001_0000_0000;
        done_t = 17'b1_0000_0010_0000_0000;
        for (int i = 2; i <= 16; i++) begin
            @(negedge clk);
            cyc_chk("t3", i);
            chk($sformatf("t3_act%0d", i), 32'(activation),
                (i <= 9) ? 32'(Relu) : 32'(Gelu));
            chk($sformatf("t3_cfgrdy%0d", i), 32'(cfg_ready),
                (i >= 3 && i <= 9) ? 0 : 1);
            if (i == 2) begin
                cfg = mk_cfg(Gelu, 2);
                cfg_valid = 1'b1;
            end else begin
                cfg_valid = 1'b0;
            end
        end
        in_valid = 1'b0;

        // T4: empty layer
        do_reset();
        cfg = mk_cfg(Relu, 0);
        cfg_valid = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            chk($sformatf("t4_busy%0d", i), 32'(busy), (i == 2) ? 1 : 0);
            chk($sformatf("t4_done%0d", i), 32'(layer_done), (i == 3) ? 1 : 0);
            chk($sformatf("t4_rdy%0d", i), 32'(in_ready), 0);
            chk($sformatf("t4_ov%0d", i), 32'(out_valid), 0);
        end
        in_valid = 1'b0;

        // T2: credit exhaustion and return
        do_reset();
        cfg = mk_cfg(Relu, 11);
        cfg_valid = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            in_valid = 1'b1;
            if (act_calc_en) cnt++;
        end
        chk("t2_accepts", 32'(cnt), 8);
        chk("t2_stalled", 32'(in_ready), 0);
        credit_ret = 1'b1;
        @(negedge clk);
        chk("t2_ret_rdy", 32'(in_ready), 1);
        @(negedge clk);
        chk("t2_both_rdy", 32'(in_ready), 1);
        credit_ret = 1'b0;
        @(negedge clk);
        chk("t2_empty_rdy", 32'(in_ready), 0);
        chk("t2_busy", 32'(busy), 1);
        credit_ret = 1'b1;
        @(negedge clk);
        chk("t2_last_rdy", 32'(in_ready), 1);
        credit_ret = 1'b0;
        @(negedge clk);
        chk("t2_end_rdy", 32'(in_ready), 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (layer_done) found = 1'b1;
        end
        chk("t2_done_seen", 32'(found), 1);
        chk("t2_err", 32'(err), 0);
        in_valid = 1'b0;

        // T5: credit overflow is sticky, counter held at max
        do_reset();
        credit_ret = 1'b1;
        @(negedge clk);
        credit_ret = 1'b0;
        chk("t5_err", 32'(err), 1);
        repeat (3) @(negedge clk);
        chk("t5_err_sticky", 32'(err), 1);
        cfg = mk_cfg(Relu, 10);
        cfg_valid = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            in_valid = 1'b1;
            if (act_calc_en) cnt++;
        end
        chk("t5_accepts", 32'(cnt), 8);
        chk("t5_err_still", 32'(err), 1);
        in_valid = 1'b0;

        // T6: reset with two vectors in flight
        do_reset();
        cfg = mk_cfg(Gelu, 4);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t6_ov", 32'(out_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rdy", 32'(in_ready), 0);
        chk("t6_act", 32'(activation), 32'(Identity));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid || busy) cnt++;
        end
        chk("t6_quiet", 32'(cnt), 0);

        // Perf: 5 stalled cycles, 13 busy cycles
        do_reset();
        cfg = mk_cfg(Relu, 9);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        in_valid = 1'b1;
        for (int i = 2; i <= 15; i++) @(negedge clk);
`ifdef ITA_ACT_CTRL_PERF_EN
        chk("perf_stall", perf_stall, 5);
        chk("perf_busy", perf_busy, 13);
`else
        chk("perf_stall", perf_stall, 0);
        chk("perf_busy", perf_busy, 0);
`endif
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
